pipeline_stall_controller: RTL

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller_pkg.sv | 22 ++
 rtl/pipeline_stall_controller_stall_counter.sv | 24 ++
 rtl/pipeline_stall_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encodings,
// default hazard/timing parameters and internal counter widths.
package pipeline_stall_controller_pkg;

    // Controller FSM; encoding 3 is never entered and falls back to RUN.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_BAD      = 2'd3
    } state_t;

    // Bubble cycles following a taken branch (1..15).
    localparam int DEF_FLUSH_CYCLES = 2;
    // Longest tolerated memory wait before forced release (1..255).
    localparam int DEF_MEM_TIMEOUT  = 15;

    // Widths sized to the largest legal FLUSH_CYCLES / MEM_TIMEOUT values.
    localparam int FLUSH_W = 4;
    localparam int WAIT_W  = 8;

endpackage

// File: rtl/pipeline_stall_controller_stall_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
module stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Count up on inc, never wrapping past the maximum value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and
// memory-wait freezes, with zero-latency combinational control outputs.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic [4:0]       id_ex_WriteReg,
    input  logic             id_ex_MemtoReg_out,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             PCWrite,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             nopMux_select,
    output logic             mem_stall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state
);

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt_next;
    logic [FLUSH_W-1:0] r_flush_cnt;
    logic [FLUSH_W-1:0] w_flush_cnt_next;
    logic               r_mem_timeout;
    logic               w_mem_timeout_next;
    logic               w_load_use;
    logic               w_stall_inc;

    // A load in EX feeding either ID source; x0 is never a real dependency.
    assign w_load_use = id_ex_MemtoReg_out && (id_ex_WriteReg != 5'd0) &&
                        ((id_ex_WriteReg == if_id_rs1) || (id_ex_WriteReg == if_id_rs2));

    // State, wait/flush counters and the sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_flush_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_flush_cnt   <= w_flush_cnt_next;
            r_mem_timeout <= w_mem_timeout_next;
        end
    end

    // Next-state and control outputs; enable=0 leaves everything held.
    always_comb begin
        w_state_next       = r_state;
        w_wait_cnt_next    = r_wait_cnt;
        w_flush_cnt_next   = r_flush_cnt;
        w_mem_timeout_next = r_mem_timeout;
        PCWrite            = 1'b0;
        if_id_write        = 1'b0;
        if_id_flush        = 1'b0;
        nopMux_select      = 1'b0;
        mem_stall          = 1'b0;

        if (reset) begin
            // Keep the ID/EX register filled with bubbles while in reset.
            nopMux_select = 1'b1;
        end else if (enable) begin
            case (r_state)
                ST_RUN: begin
                    if (mem_req && !mem_ack) begin
                        mem_stall       = 1'b1;
                        w_state_next    = ST_MEM_WAIT;
                        w_wait_cnt_next = '0;
                    end else if (ex_branch_taken) begin
                        PCWrite       = 1'b1;
                        if_id_flush   = 1'b1;
                        nopMux_select = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_state_next     = ST_FLUSH;
                            w_flush_cnt_next = FLUSH_LOAD;
                        end
                    end else if (w_load_use) begin
                        nopMux_select = 1'b1;
                    end else begin
                        PCWrite     = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    mem_stall = 1'b1;
                    if (mem_ack) begin
                        w_state_next = ST_RUN;
                    end else if (r_wait_cnt >= WAIT_LAST) begin
                        w_mem_timeout_next = 1'b1;
                        w_state_next       = ST_RUN;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    PCWrite       = 1'b1;
                    if_id_flush   = 1'b1;
                    nopMux_select = 1'b1;
                    // The counter holds the remaining flush cycles including this one.
                    if (r_flush_cnt <= FLUSH_W'(1)) begin
                        w_flush_cnt_next = '0;
                        w_state_next     = ST_RUN;
                    end else begin
                        w_flush_cnt_next = r_flush_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    assign w_stall_inc = enable && !reset && (!PCWrite || if_id_flush);

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clock (clock),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_count)
    );

    assign mem_timeout = r_mem_timeout;
    assign state       = r_state;

endmodule
